// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and the power-up init table
// for the 16x2 text LCD controller.
package lcd_pkg;

  localparam int unsigned CNT_W    = 22;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned COL_W    = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned INIT_LEN = 5;

  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_OFF   = 8'h08;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CMD_ON    = 8'h0C;
  localparam logic [7:0] LCD_ADDR_L0   = 8'h80;
  localparam logic [7:0] LCD_ADDR_L1   = 8'hC0;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_SETADDR,
    ST_FETCH,
    ST_LOAD,
    ST_WRITE,
    ST_GAP
  } main_state_e;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_EN_HI,
    BUS_HOLD,
    BUS_WAIT
  } bus_phase_e;

  typedef struct packed {
    logic [7:0] code;
    logic       long_wait;
  } init_entry_t;

  // Init ROM: command byte plus whether it needs the long (clear) wait.
  function automatic init_entry_t init_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return '{code: LCD_CMD_FUNC,  long_wait: 1'b0};
      3'd1:    return '{code: LCD_CMD_OFF,   long_wait: 1'b0};
      3'd2:    return '{code: LCD_CMD_CLEAR, long_wait: 1'b1};
      3'd3:    return '{code: LCD_CMD_ENTRY, long_wait: 1'b0};
      default: return '{code: LCD_CMD_ON,    long_wait: 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write bus cycle (setup, EN high, hold, post-wait) on a single
// down-counter; a delay-only start reuses the counter for power-up/frame idling.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 1000000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLEAR   = 100000,
  parameter int unsigned FRAME_GAP = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       delay_only,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done_c,
  output logic       idle_c,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(FRAME_GAP - 1);

  bus_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;

  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= BUS_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    idle_c  = (phase_q == BUS_IDLE);
    done_c  = (phase_q == BUS_WAIT) && (cnt_q == '0);

    if (phase_q != BUS_IDLE && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

    case (phase_q)
      BUS_SETUP: if (cnt_q == '0) begin
        phase_d = BUS_EN_HI;
        en_d    = 1'b1;
        cnt_d   = LD_EN;
      end
      BUS_EN_HI: if (cnt_q == '0) begin
        phase_d = BUS_HOLD;
        en_d    = 1'b0;
        cnt_d   = LD_HOLD;
      end
      BUS_HOLD: if (cnt_q == '0) begin
        phase_d = BUS_WAIT;
        cnt_d   = long_q ? LD_CLEAR : LD_CMD;
      end
      BUS_WAIT: if (cnt_q == '0) phase_d = BUS_IDLE;
      default: ;
    endcase

    // A new request is taken when idle or in the last wait cycle.
    if (start && (idle_c || done_c)) begin
      if (delay_only) begin
        phase_d = BUS_WAIT;
        cnt_d   = long_wait ? LD_GAP : LD_PWR;
      end else begin
        phase_d = BUS_SETUP;
        cnt_d   = LD_SETUP;
        rs_d    = rs;
        data_d  = data;
        long_d  = long_wait;
      end
    end
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// Write-only HD44780 16x2 sequencer: power-up init, then continuous refresh of
// both lines from a character source. Define LCD_FRAME_GAP_EN for an idle gap between frames.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 1000000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 16,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLEAR   = 100000,
  parameter int unsigned FRAME_GAP = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              char_req,
  output logic [ADDR_W-1:0] char_addr,
  input  logic [7:0]        char_data,
  output logic [7:0]        lcd_data,
  output logic              lcd_en,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_on,
  output logic              init_done,
  output logic              frame_done
);

  main_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              line_q, line_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [7:0]        byte_q, byte_d;
  logic              char_req_q, char_req_d;
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;
  logic              init_done_q, init_done_d;
  logic              frame_done_q, frame_done_d;
  logic              lcd_on_q, lcd_on_d;

  logic              bus_start_c, bus_delay_c, bus_rs_c, bus_long_c;
  logic [7:0]        bus_data_c;
  logic              bus_done_c, bus_idle_c;
  init_entry_t       rom_c;

  assign char_req   = char_req_q;
  assign char_addr  = char_addr_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign lcd_on     = lcd_on_q;
  assign lcd_rw     = 1'b0;

  lcd_bus_cycle #(
    .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .FRAME_GAP(FRAME_GAP)
  ) u_bus (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bus_start_c),
    .delay_only (bus_delay_c),
    .rs         (bus_rs_c),
    .data       (bus_data_c),
    .long_wait  (bus_long_c),
    .done_c     (bus_done_c),
    .idle_c     (bus_idle_c),
    .lcd_en     (lcd_en),
    .lcd_rs     (lcd_rs),
    .lcd_data   (lcd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_POWERUP;
      idx_q        <= '0;
      line_q       <= 1'b0;
      col_q        <= '0;
      byte_q       <= 8'h00;
      char_req_q   <= 1'b0;
      char_addr_q  <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      lcd_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      line_q       <= line_d;
      col_q        <= col_d;
      byte_q       <= byte_d;
      char_req_q   <= char_req_d;
      char_addr_q  <= char_addr_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      lcd_on_q     <= lcd_on_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    line_d       = line_q;
    col_d        = col_q;
    byte_d       = byte_q;
    char_req_d   = 1'b0;
    char_addr_d  = char_addr_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    lcd_on_d     = 1'b1;
    bus_start_c  = 1'b0;
    bus_delay_c  = 1'b0;
    bus_rs_c     = 1'b0;
    bus_data_c   = 8'h00;
    bus_long_c   = 1'b0;
    rom_c        = init_rom(idx_q);

    case (state_q)
      ST_POWERUP: begin
        bus_start_c = bus_idle_c;
        bus_delay_c = 1'b1;
        if (bus_done_c) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: begin
        bus_start_c = bus_idle_c;
        bus_data_c  = rom_c.code;
        bus_long_c  = rom_c.long_wait;
        if (bus_done_c) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            line_d      = 1'b0;
            col_d       = '0;
            state_d     = ST_SETADDR;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SETADDR: begin
        bus_start_c = bus_idle_c;
        bus_data_c  = line_q ? LCD_ADDR_L1 : LCD_ADDR_L0;
        if (bus_done_c) begin
          char_req_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        byte_d  = char_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus_start_c = bus_idle_c;
        bus_rs_c    = 1'b1;
        bus_data_c  = byte_q;
        if (bus_done_c) begin
          col_d = '0;
          if (col_q != COL_W'(15)) begin
            col_d      = col_q + COL_W'(1);
            char_req_d = 1'b1;
            state_d    = ST_FETCH;
          end else if (!line_q) begin
            line_d  = 1'b1;
            state_d = ST_SETADDR;
          end else begin
            frame_done_d = 1'b1;
            line_d       = 1'b0;
`ifdef LCD_FRAME_GAP_EN
            state_d      = ST_GAP;
`else
            state_d      = ST_SETADDR;
`endif
          end
        end
      end
`ifdef LCD_FRAME_GAP_EN
      // Idle via the bus counter; the line-0 address is handed over in the last gap cycle.
      ST_GAP: begin
        bus_start_c = bus_idle_c || bus_done_c;
        bus_delay_c = !bus_done_c;
        bus_long_c  = !bus_done_c;
        bus_data_c  = LCD_ADDR_L0;
        if (bus_done_c) state_d = ST_SETADDR;
      end
`endif
      default: state_d = ST_POWERUP;
    endcase

    if (char_req_d) char_addr_d = {line_d, col_d};
  end

endmodule
